// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, FSM state type and opcode helpers
// for the ALU op sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_ROL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SGT = 4'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } seq_state_t;

  // Opcodes 8..15 are not defined for the ALU and come back as errors.
  function automatic logic op_is_err(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic op_has_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - first-word-fall-through response FIFO; payload and
// pointers reset to zero, push and pop in one cycle allowed even when full.
module alu_rsp_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_tvalid,
  input  logic [DATA_W-1:0]        in_tdata,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic [DATA_W-1:0]        out_tdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign out_tvalid = (cnt_q != '0);
  assign out_tdata  = mem_q[rd_ptr_q];
  assign count      = cnt_q;
  assign do_pop     = out_tvalid && out_tready;
  assign do_push    = in_tvalid && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = in_tdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - IDLE/EXEC sequencer driving an external combinational ALU
// into a response FIFO; define ALU_SEQ_ACCUM_EN for the accumulator operand path.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shift,
`ifdef ALU_SEQ_ACCUM_EN
  input  logic             cmd_use_acc,
`endif
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy
);

  localparam int RSP_W = WIDTH + 2;
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  seq_state_t       state_q, state_d;
  logic             ready_en_q, ready_en_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_input1_q, alu_input1_d;
  logic [WIDTH-1:0] alu_input2_q, alu_input2_d;
  logic [4:0]       alu_shift_q, alu_shift_d;
  logic             stage_valid_q, stage_valid_d;
  logic [RSP_W-1:0] stage_data_q, stage_data_d;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_tvalid;
  logic [RSP_W-1:0] fifo_tdata;
  logic [WIDTH-1:0] op_a;
  logic             accept;
  logic             exec_err;
  logic             exec_carry;
  logic [WIDTH-1:0] exec_result;

`ifdef ALU_SEQ_ACCUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  assign op_a = cmd_use_acc ? acc_q : cmd_a;
`else
  assign op_a = cmd_a;
`endif

  // A result sitting in the staging register already owns a FIFO slot.
  assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid_q};
  assign cmd_ready   = ready_en_q && (state_q == ST_IDLE) &&
                       (occupancy < (CNT_W+1)'(RSP_DEPTH));
  assign accept      = cmd_valid && cmd_ready;
  assign exec_err    = op_is_err(alu_opcode_q);
  assign exec_carry  = op_has_carry(alu_opcode_q) ? alu_carry : 1'b0;
  assign exec_result = exec_err ? '0 : alu_result;

  assign alu_opcode     = alu_opcode_q;
  assign alu_input1     = alu_input1_q;
  assign alu_input2     = alu_input2_q;
  assign alu_shiftValue = alu_shift_q;

  assign busy = (state_q != ST_IDLE) || stage_valid_q || fifo_tvalid;

  always_comb begin
    state_d       = state_q;
    ready_en_d    = 1'b1;
    alu_opcode_d  = alu_opcode_q;
    alu_input1_d  = alu_input1_q;
    alu_input2_d  = alu_input2_q;
    alu_shift_d   = alu_shift_q;
    stage_valid_d = 1'b0;
    stage_data_d  = stage_data_q;
`ifdef ALU_SEQ_ACCUM_EN
    acc_d         = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_opcode_d = cmd_opcode;
          alu_input1_d = op_a;
          alu_input2_d = cmd_b;
          alu_shift_d  = cmd_shift;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Capture at end of EXEC; the FIFO write follows on the next edge.
        stage_valid_d = 1'b1;
        stage_data_d  = {exec_err, exec_carry, exec_result};
        state_d       = ST_IDLE;
`ifdef ALU_SEQ_ACCUM_EN
        if (!exec_err) begin
          acc_d = alu_result;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ready_en_q    <= 1'b0;
      alu_opcode_q  <= '0;
      alu_input1_q  <= '0;
      alu_input2_q  <= '0;
      alu_shift_q   <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
`ifdef ALU_SEQ_ACCUM_EN
      acc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ready_en_q    <= ready_en_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_input1_q  <= alu_input1_d;
      alu_input2_q  <= alu_input2_d;
      alu_shift_q   <= alu_shift_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
`ifdef ALU_SEQ_ACCUM_EN
      acc_q         <= acc_d;
`endif
    end
  end

  alu_rsp_fifo #(
    .DATA_W (RSP_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_tvalid  (stage_valid_q),
    .in_tdata   (stage_data_q),
    .out_tvalid (fifo_tvalid),
    .out_tready (rsp_ready),
    .out_tdata  (fifo_tdata),
    .count      (fifo_count)
  );

  assign rsp_valid = fifo_tvalid;
  assign {rsp_err, rsp_carry, rsp_result} = fifo_tdata;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ALU operand/result width.
REQ-002 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries (power of two, >=2).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-004 cmd_valid in 1; cmd_ready out 1; command handshake.
REQ-005 cmd_opcode in 4; cmd_a in WIDTH; cmd_b in WIDTH; cmd_shift in 5; command payload.
REQ-006 alu_opcode out 4; alu_input1 out WIDTH; alu_input2 out WIDTH; alu_shiftValue out 5; drive the external combinational ALU.
REQ-007 alu_result in WIDTH; alu_carry in 1; ALU outputs.
REQ-008 rsp_valid out 1; rsp_ready in 1; rsp_result out WIDTH; rsp_carry out 1; rsp_err out 1; response handshake.
REQ-009 busy out 1; high whenever state is not IDLE or FIFO non-empty.

Function
REQ-010 FSM states SHALL be IDLE and EXEC only.
REQ-011 cmd_ready SHALL be 1 only in IDLE with FIFO occupancy < RSP_DEPTH.
REQ-012 cmd_valid&cmd_ready in IDLE SHALL register opcode/a/b/shift onto alu_* outputs and move to EXEC next cycle.
REQ-013 alu_* outputs SHALL hold stable for the whole EXEC cycle and until the next accepted command.
REQ-014 At end of EXEC, alu_result/alu_carry SHALL be pushed into the FIFO; FSM returns to IDLE; throughput one op per 2 cycles.
REQ-015 Latency: cmd handshake edge N -> rsp_valid high after edge N+2 when FIFO was empty.
REQ-016 rsp_carry SHALL equal alu_carry for opcodes 0 (ADD) and 1 (SUB), else 0.
REQ-017 rsp_err SHALL be 1 and rsp_result 0 for opcodes 8..15; opcode still forwarded to ALU.
REQ-018 FIFO is first-word-fall-through; rsp_valid = non-empty; pop on rsp_valid&rsp_ready.
REQ-019 Simultaneous push and pop SHALL keep occupancy unchanged, including at full; pointers wrap modulo RSP_DEPTH.
REQ-020 Push can never overflow: acceptance in IDLE reserves a slot via REQ-011.
REQ-021 rsp_* payload SHALL be held stable while rsp_valid&!rsp_ready.

Reset
REQ-022 rst SHALL force IDLE, FIFO empty, alu_* outputs 0, rsp_valid 0, rsp_* payload 0, cmd_ready 0 while asserted, busy 0.
REQ-023 rst during EXEC SHALL discard the in-flight op; no response produced for it.
REQ-024 cmd_ready SHALL rise on the first clk edge after rst deassertion.

Configuration
REQ-025 Macro ALU_SEQ_ACCUM_EN, when defined, SHALL add input cmd_use_acc (1 bit) and an accumulator register (reset 0) loaded with every pushed non-error result.
REQ-026 With ALU_SEQ_ACCUM_EN, cmd_use_acc=1 SHALL substitute the accumulator for cmd_a on alu_input1; without it, port and register SHALL be absent and alu_input1 always takes cmd_a.

Structure
REQ-027 Opcode constants (ADD 0, SUB 1, AND 2, OR 3, ROL 4, SRA 5, XOR 6, SGT 7) and FSM state type SHALL live in shared package alu_pkg.
REQ-028 The response FIFO SHALL be sub-module alu_rsp_fifo (WIDTH+2 bits wide, RSP_DEPTH deep).

Verification
REQ-029 ADD a=0xF0 b=0x20 -> rsp_result 0x10, rsp_carry 1, rsp_err 0, rsp_valid 2 cycles after handshake.
REQ-030 SUB a=0x05 b=0x07 -> 0xFE, rsp_carry 1; ROL a=0x81 shift=1 -> 0x03, rsp_carry 0; SRA a=0x80 shift=2 -> 0xE0.
REQ-031 rsp_ready=0, issue 5 commands -> 4 accepted, cmd_ready stays 0; then rsp_ready=1 -> responses drain in order, 5th accepted.
REQ-032 opcode 9 a=0x12 b=0x34 -> rsp_result 0x00, rsp_err 1, rsp_carry 0.
REQ-033 rst asserted during EXEC of ADD 0x01+0x01 -> no response, all outputs 0, cmd_ready 1 one edge after release.
REQ-034 With ALU_SEQ_ACCUM_EN: ADD 0x03+0x04, then ADD cmd_use_acc=1 b=0x10 -> responses 0x07, 0x17.
